// File: rtl/quantization_scheduler_if.sv
// Signal bundle between the tensor streamer / quantizer / writer side and the scheduler.
// master = environment that drives jobs and results, slave = the scheduler itself.
interface quantization_scheduler_if #(
  parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16,
  parameter int NUM_CHANNELS                = 8,
  parameter int CNT_W                       = 16
);
  localparam int BW_W = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1;
  localparam int CH_W = $clog2(NUM_CHANNELS);

  logic                                   scale_wr_en;
  logic [CH_W-1:0]                        scale_wr_addr;
  logic [15:0]                            scale_wr_data;
  logic                                   start;
  logic [CNT_W-1:0]                       num_elements;
  logic [CNT_W-1:0]                       elems_per_chan;
  logic [BW_W-1:0]                        bitwidth_cfg;
  logic                                   in_valid;
  logic                                   in_ready;
  logic [15:0]                            in_data;
  logic                                   q_values_rdy;
  logic [15:0]                            q_fp_value;
  logic [15:0]                            q_scale_fp;
  logic [BW_W-1:0]                        q_bitwidth;
  logic                                   q_result_rdy;
  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] q_result;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] out_data;
  logic                                   busy;
  logic                                   done;
  logic                                   overflow_err;

  modport master (
    output scale_wr_en, scale_wr_addr, scale_wr_data, start, num_elements,
           elems_per_chan, bitwidth_cfg, in_valid, in_data, q_result_rdy,
           q_result, out_ready,
    input  in_ready, q_values_rdy, q_fp_value, q_scale_fp, q_bitwidth,
           out_valid, out_data, busy, done, overflow_err
  );

  modport slave (
    input  scale_wr_en, scale_wr_addr, scale_wr_data, start, num_elements,
           elems_per_chan, bitwidth_cfg, in_valid, in_data, q_result_rdy,
           q_result, out_ready,
    output in_ready, q_values_rdy, q_fp_value, q_scale_fp, q_bitwidth,
           out_valid, out_data, busy, done, overflow_err
  );
endinterface

// File: rtl/quantization_scheduler.sv
// Issues bfloat16 values with their per-channel scale to the quantizer, one per cycle,
// under a credit scheme that reserves a result-FIFO slot for every outstanding issue.
module quantization_scheduler #(
  parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16,
  parameter int NUM_CHANNELS                = 8,
  parameter int FIFO_DEPTH                  = 8,
  parameter int CNT_W                       = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  quantization_scheduler_if.slave  bus
);
  localparam int BW_W  = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1;
  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = FC_W + 1;
  localparam int DW    = MAX_BITWIDTH_QUANTIZED_DATA;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_epc;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_elem;
  logic [CH_W-1:0]  r_chan;
  logic [BW_W-1:0]  r_bw;
  logic [FC_W-1:0]  r_inflight;
  logic [FC_W-1:0]  r_count;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_qv;
  logic [15:0]      r_qfp;
  logic [15:0]      r_qscale;
  logic             r_ovf;
  logic [15:0]      r_scale_tbl [NUM_CHANNELS];
  logic [DW-1:0]    r_fifo_mem  [FIFO_DEPTH];

  logic w_busy, w_done, w_in_ready;
  logic w_start, w_hs, w_full, w_pop, w_push_ok, w_dec, w_credit_ok, w_out_valid;

  assign w_start     = bus.start && (r_state == S_IDLE);
  assign w_hs        = bus.in_valid && w_in_ready;
  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == FC_W'(FIFO_DEPTH));
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_push_ok   = bus.q_result_rdy && (!w_full || w_pop);
  assign w_dec       = bus.q_result_rdy && (r_inflight != '0);
  // Outstanding issues hold a slot, so a result can always land regardless of latency
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < SUM_W'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = (bus.num_elements != '0) ? S_RUN : S_DONE;
      S_RUN:   if (r_issued == r_num) w_state_next = S_DRAIN;
      S_DRAIN: if ((r_inflight == '0) && (r_count == '0)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_done     = (r_state == S_DONE);
    w_in_ready = (r_state == S_RUN) && (r_issued < r_num) && w_credit_ok;
  end

  always_ff @(posedge clk) begin
    if (bus.scale_wr_en && (r_state == S_IDLE))
      r_scale_tbl[bus.scale_wr_addr] <= bus.scale_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_num    <= '0;
      r_epc    <= '0;
      r_bw     <= '0;
      r_issued <= '0;
      r_elem   <= '0;
      r_chan   <= '0;
      r_qv     <= 1'b0;
      r_qfp    <= '0;
      r_qscale <= '0;
    end else begin
      r_qv <= w_hs;
      if (w_start) begin
        r_num    <= bus.num_elements;
        r_epc    <= (bus.elems_per_chan == '0) ? CNT_W'(1) : bus.elems_per_chan;
        r_bw     <= bus.bitwidth_cfg;
        r_issued <= '0;
        r_elem   <= '0;
        r_chan   <= '0;
      end else if (w_hs) begin
        r_issued <= r_issued + CNT_W'(1);
        r_qfp    <= bus.in_data;
        r_qscale <= r_scale_tbl[r_chan];
        if (r_elem == r_epc - CNT_W'(1)) begin
          r_elem <= '0;
          r_chan <= r_chan + CH_W'(1);
        end else begin
          r_elem <= r_elem + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_hs && !w_dec)      r_inflight <= r_inflight + FC_W'(1);
      else if (!w_hs && w_dec) r_inflight <= r_inflight - FC_W'(1);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{(FC_W-1){1'b0}}, w_push_ok} - {{(FC_W-1){1'b0}}, w_pop};
      if (w_start)
        r_ovf <= 1'b0;
      else if (bus.q_result_rdy && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo_mem[r_wr_ptr] <= bus.q_result;
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.q_values_rdy = r_qv;
  assign bus.q_fp_value   = r_qfp;
  assign bus.q_scale_fp   = r_qscale;
  assign bus.q_bitwidth   = r_bw;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = w_out_valid ? r_fifo_mem[r_rd_ptr] : '0;
  assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_quantization_scheduler.sv
// Randomized bench for quantization_scheduler: a queue-based job/FIFO model plus a
// fixed-latency quantizer model, checked every cycle, with directed scenarios on top.
module tb_quantization_scheduler;
  localparam int MAXBW = 16;
  localparam int NC    = 8;
  localparam int FD    = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  quantization_scheduler_if #(.MAX_BITWIDTH_QUANTIZED_DATA(MAXBW), .NUM_CHANNELS(NC), .CNT_W(CNT_W)) bus ();

  quantization_scheduler #(
    .MAX_BITWIDTH_QUANTIZED_DATA(MAXBW), .NUM_CHANNELS(NC), .FIFO_DEPTH(FD), .CNT_W(CNT_W)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct { logic [15:0] fp; logic [15:0] sc; } iss_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sw_tbl [NC];
  iss_t        exp_iss[$];
  logic [15:0] exp_out[$];
  int          due_q[$];
  logic [15:0] dat_q[$];
  logic [15:0] scale_log[$];
  int          ncyc = 0;
  int          lat = 2;
  bit          inject = 1'b0;
  bit          job_active = 1'b0;
  int          job_n = 0, job_epc = 1, job_issued = 0, job_bw = 0;
  int          inflight_m = 0;
  bit          ovf_m = 1'b0;
  int          done_cnt = 0, issue_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference model and per-cycle comparison
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rstn) begin
        exp_iss.delete(); exp_out.delete(); due_q.delete(); dat_q.delete();
        job_active = 1'b0; inflight_m = 0; ovf_m = 1'b0; job_issued = 0;
      end else begin
        bit exp_rdy;
        bit hs;
        bit dec;
        exp_rdy = job_active && (job_issued < job_n) && ((exp_out.size() + inflight_m) < FD);
        chk("out_valid", bus.out_valid, exp_out.size() != 0);
        if (exp_out.size() != 0) chk("out_data", bus.out_data, exp_out[0]);
        chk("overflow_err", bus.overflow_err, ovf_m);
        chk("in_ready", bus.in_ready, exp_rdy);
        if (bus.q_values_rdy) begin
          chk("issue_expected", exp_iss.size() != 0, 1);
          if (exp_iss.size() != 0) begin
            iss_t e;
            e = exp_iss.pop_front();
            chk("q_fp_value", bus.q_fp_value, e.fp);
            chk("q_scale_fp", bus.q_scale_fp, e.sc);
            chk("q_bitwidth", bus.q_bitwidth, job_bw);
          end
          scale_log.push_back(bus.q_scale_fp);
          issue_cnt++;
          due_q.push_back(ncyc + lat);
          dat_q.push_back(bus.q_fp_value ^ {bus.q_scale_fp[7:0], bus.q_scale_fp[15:8]});
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_when_drained", (job_issued == job_n) && (inflight_m == 0) && (exp_out.size() == 0), 1);
          job_active = 1'b0;
        end
        // Events taking effect at the coming edge
        if (bus.out_valid && bus.out_ready && exp_out.size() != 0) void'(exp_out.pop_front());
        hs  = bus.in_valid && exp_rdy;
        dec = bus.q_result_rdy && (inflight_m > 0);
        if (bus.q_result_rdy) begin
          if (exp_out.size() < FD) exp_out.push_back(bus.q_result);
          else ovf_m = 1'b1;
        end
        if (hs) begin
          exp_iss.push_back(iss_t'{fp: bus.in_data, sc: sw_tbl[(job_issued / job_epc) % NC]});
          job_issued++;
        end
        inflight_m = inflight_m + int'(hs) - int'(dec);
        if (bus.start && !bus.busy) begin
          job_active = 1'b1;
          job_n      = int'(bus.num_elements);
          job_epc    = (bus.elems_per_chan == 0) ? 1 : int'(bus.elems_per_chan);
          job_bw     = int'(bus.bitwidth_cfg);
          job_issued = 0;
          ovf_m      = 1'b0;
        end
        if (bus.scale_wr_en && !bus.busy) sw_tbl[bus.scale_wr_addr] = bus.scale_wr_data;
      end
    end
  end

  // Fixed-latency quantizer model
  initial begin
    bus.q_result_rdy = 1'b0;
    bus.q_result     = '0;
    forever begin
      @(posedge clk); #1;
      bus.q_result_rdy = 1'b0;
      if (!rstn) begin
        bus.q_result_rdy = 1'b0;
      end else if (inject) begin
        bus.q_result_rdy = 1'b1;
        bus.q_result     = 16'hDEAD;
      end else if (due_q.size() != 0 && due_q[0] <= ncyc + 1) begin
        void'(due_q.pop_front());
        bus.q_result_rdy = 1'b1;
        bus.q_result     = dat_q.pop_front();
      end
    end
  end

  task automatic wr_scale(input int ch, input logic [15:0] val);
    @(posedge clk); #1;
    bus.scale_wr_en   = 1'b1;
    bus.scale_wr_addr = ch[2:0];
    bus.scale_wr_data = val;
    @(posedge clk); #1;
    bus.scale_wr_en   = 1'b0;
  endtask

  task automatic start_job(input int n, input int epc, input int bw, input int l);
    @(posedge clk); #1;
    lat = l;
    scale_log.delete();
    done_cnt = 0;
    issue_cnt = 0;
    bus.start          = 1'b1;
    bus.num_elements   = n[CNT_W-1:0];
    bus.elems_per_chan = epc[CNT_W-1:0];
    bus.bitwidth_cfg   = bw[4:0];
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.bitwidth_cfg = 5'($urandom_range(16));
  endtask

  task automatic drive(input int cycles, input int vpct, input int rpct, input bit until_idle);
    int k;
    for (k = 0; k < cycles; k++) begin
      if (until_idle && !job_active && !bus.busy) break;
      bus.in_valid  = ($urandom_range(99) < vpct);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(99) < rpct);
      @(posedge clk); #1;
    end
    if (until_idle) chk("job_timeout", job_active || bus.busy, 0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int seq4[10];
    bus.scale_wr_en = 0; bus.scale_wr_addr = '0; bus.scale_wr_data = '0;
    bus.start = 0; bus.num_elements = '0; bus.elems_per_chan = '0; bus.bitwidth_cfg = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    for (int i = 0; i < NC; i++) sw_tbl[i] = 16'h0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", bus.busy, 0);          chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0); chk("rst_done", bus.done, 0);
    chk("rst_q_values_rdy", bus.q_values_rdy, 0); chk("rst_overflow", bus.overflow_err, 0);
    chk("rst_q_bitwidth", bus.q_bitwidth, 0);     chk("rst_q_fp", bus.q_fp_value, 0);
    chk("rst_q_scale", bus.q_scale_fp, 0);        chk("rst_out_data", bus.out_data, 0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < NC; i++) wr_scale(i, 16'h3F00 + 16'(i));

    // T1: scale per channel, two elements per channel
    wr_scale(0, 16'h3F80); wr_scale(1, 16'h4000);
    start_job(4, 2, 8, 2);
    drive(500, 100, 100, 1);
    chk("T1_issues", scale_log.size(), 4);
    if (scale_log.size() == 4) begin
      chk("T1_scale0", scale_log[0], 16'h3F80); chk("T1_scale1", scale_log[1], 16'h3F80);
      chk("T1_scale2", scale_log[2], 16'h4000); chk("T1_scale3", scale_log[3], 16'h4000);
    end
    chk("T1_done_once", done_cnt, 1);
    $display("job T1: issues=%0d done=%0d", issue_cnt, done_cnt);

    // T2: empty job goes straight through DONE
    @(posedge clk); #1;
    done_cnt = 0; issue_cnt = 0;
    bus.start = 1'b1; bus.num_elements = '0; bus.elems_per_chan = 16'd1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("T2_busy_in_done", bus.busy, 1); chk("T2_done_pulse", bus.done, 1);
    @(negedge clk);
    chk("T2_busy_after", bus.busy, 0); chk("T2_done_after", bus.done, 0);
    chk("T2_no_issue", issue_cnt, 0);  chk("T2_done_once", done_cnt, 1);
    $display("job T2: issues=%0d done=%0d", issue_cnt, done_cnt);

    // T3: blocked output stops issue at FIFO_DEPTH credits
    start_job(20, 3, 4, 3);
    drive(40, 100, 0, 0);
    @(negedge clk);
    chk("T3_stalled_issues", issue_cnt, 8);
    chk("T3_in_ready_stuck", bus.in_ready, 0);
    @(posedge clk); #1;
    drive(1000, 100, 100, 1);
    chk("T3_total_issues", issue_cnt, 20); chk("T3_done_once", done_cnt, 1);
    $display("job T3: issues=%0d done=%0d", issue_cnt, done_cnt);

    // T4: channel wrap with one element per channel
    for (int i = 0; i < NC; i++) wr_scale(i, 16'h4100 + 16'(i));
    seq4 = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    start_job(10, 1, 12, 1);
    drive(1000, 80, 90, 1);
    chk("T4_issues", scale_log.size(), 10);
    if (scale_log.size() == 10)
      for (int i = 0; i < 10; i++) chk($sformatf("T4_chan%0d", i), scale_log[i], 16'h4100 + 16'(seq4[i]));
    $display("job T4: issues=%0d done=%0d", issue_cnt, done_cnt);

    // T5: spurious result into a full FIFO
    start_job(8, 2, 5, 2);
    drive(30, 100, 0, 0);
    @(negedge clk) inject = 1'b1;
    @(negedge clk) inject = 1'b0;
    @(negedge clk);
    chk("T5_overflow_set", bus.overflow_err, 1);
    @(posedge clk); #1;
    drive(1000, 0, 100, 1);
    chk("T5_done_once", done_cnt, 1);
    $display("job T5: issues=%0d done=%0d overflow=%0d", issue_cnt, done_cnt, bus.overflow_err);
    start_job(3, 1, 7, 2);
    @(negedge clk);
    chk("T5_overflow_cleared", bus.overflow_err, 0);
    @(posedge clk); #1;
    drive(500, 100, 100, 1);

    // T6: reset during RUN with three results outstanding
    start_job(12, 2, 6, 6);
    begin
      int k;
      for (k = 0; k < 50 && inflight_m != 3; k++) begin
        bus.in_valid = 1'b1; bus.in_data = 16'($urandom); bus.out_ready = 1'b0;
        @(posedge clk); #1;
      end
      chk("T6_reach_inflight3", inflight_m, 3);
    end
    rstn = 1'b0;
    #1;
    chk("T6_busy", bus.busy, 0); chk("T6_in_ready", bus.in_ready, 0); chk("T6_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < NC; i++) wr_scale(i, 16'h3E00 + 16'(i * 3));
    start_job(6, 1, 8, 2);
    drive(500, 100, 100, 1);
    chk("T6_new_job_issues", issue_cnt, 6); chk("T6_new_job_done", done_cnt, 1);
    $display("job T6: issues=%0d done=%0d", issue_cnt, done_cnt);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      int n, epc, l;
      n   = $urandom_range(30, 1);
      epc = $urandom_range(4);
      l   = $urandom_range(6, 1);
      for (int i = 0; i < NC; i++) wr_scale(i, 16'($urandom));
      start_job(n, epc, $urandom_range(16), l);
      drive(3000, $urandom_range(100, 40), $urandom_range(100, 30), 1);
      chk("rand_issues", issue_cnt, n);
      chk("rand_done_once", done_cnt, 1);
      $display("job R%0d: n=%0d epc=%0d lat=%0d issues=%0d done=%0d", j, n, epc, l, issue_cnt, done_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
